// File: rtl/maze_pkg.sv
// Shared types and constants for the maze read arbiter: cell encoding, requester ids,
// arbiter state encoding and the read tag carried alongside each outstanding read.
package maze_pkg;

    localparam logic FLOOR = 1'b0;
    localparam logic WALL  = 1'b1;

    localparam logic REQ_DISP = 1'b0;
    localparam logic REQ_PLYR = 1'b1;

    localparam int unsigned DEF_WIDTH  = 30;
    localparam int unsigned DEF_HEIGHT = 40;
    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned SEED_W     = 11;

    typedef enum logic [2:0] {
        StIdle,
        StGenPulse,
        StGenClear,
        StGenWait,
        StServe
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic id;
        logic oob;
    } rd_tag_t;

endpackage

// File: rtl/maze_tag_pipe.sv
// Fixed-depth shift register of read tags; each tag emerges DEPTH cycles after it is pushed.
// A synchronous flush empties every stage.
module maze_tag_pipe
    import maze_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    flush,
    input  rd_tag_t push,
    output rd_tag_t tail
);

    rd_tag_t [DEPTH-1:0] pipe_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_q <= '0;
        end else if (flush) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[DEPTH-2:0], push};
        end
    end

    assign tail = pipe_q[DEPTH-1];

endmodule

// File: rtl/maze_read_arbiter.sv
// Sequences maze generation, then shares the single maze read port between the display
// renderer and the player collision checker, routing each returned cell bit to its requester.
module maze_read_arbiter
    import maze_pkg::*;
#(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned HEIGHT       = DEF_HEIGHT,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned READ_LAT     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_game,
    input  logic [SEED_W-1:0] seed_in,
    output logic [SEED_W-1:0] seed_out,
    output logic              gen_start,
    input  logic              gen_end,
    output logic              maze_ready,
    output logic [ADDR_W-1:0] maze_address,
    input  logic              maze_data,
    input  logic              disp_req,
    input  logic [5:0]        disp_x,
    input  logic [5:0]        disp_y,
    output logic              disp_grant,
    output logic              disp_valid,
    output logic              disp_data,
    input  logic              plyr_req,
    input  logic [5:0]        plyr_x,
    input  logic [5:0]        plyr_y,
    output logic              plyr_grant,
    output logic              plyr_valid,
    output logic              plyr_data
);

    localparam int unsigned CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned PIPE_DEPTH = READ_LAT + 2;

    arb_state_e        state_q, state_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic [CNT_W-1:0]  deny_q, deny_d;
    logic [ADDR_W-1:0] addr_q;
    logic              data_q;

    logic              serve, accept, plyr_wins, any_grant;
    logic              gnt_id, gnt_oob, resp_data, flush;
    logic [5:0]        gnt_x, gnt_y;
    logic [ADDR_W-1:0] gnt_addr;
    rd_tag_t           push_tag, tail_tag;

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        unique case (state_q)
            StIdle: begin
                if (start_game) begin
                    seed_d  = seed_in;
                    state_d = StGenPulse;
                end
            end
            StGenPulse: state_d = StGenClear;
            // gen_end may still be high from the previous maze; wait for it to drop first
            StGenClear: if (!gen_end) state_d = StGenWait;
            StGenWait:  if (gen_end) state_d = StServe;
            StServe: begin
                if (start_game) begin
                    seed_d  = seed_in;
                    state_d = StGenPulse;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign serve      = (state_q == StServe);
    assign accept     = serve && !start_game;
    assign plyr_wins  = plyr_req && (!disp_req || (deny_q == CNT_W'(STARVE_LIMIT)));
    assign plyr_grant = accept && plyr_wins;
    assign disp_grant = accept && disp_req && !plyr_wins;
    assign any_grant  = disp_grant || plyr_grant;

    always_comb begin
        deny_d = deny_q;
        if (!plyr_req || plyr_grant) begin
            deny_d = '0;
        end else if (disp_grant) begin
            deny_d = deny_q + 1'b1;
        end
    end

    assign gnt_id   = plyr_grant ? REQ_PLYR : REQ_DISP;
    assign gnt_x    = plyr_grant ? plyr_x : disp_x;
    assign gnt_y    = plyr_grant ? plyr_y : disp_y;
    assign gnt_oob  = (32'(gnt_x) >= WIDTH) || (32'(gnt_y) >= HEIGHT);
    assign gnt_addr = ADDR_W'(WIDTH) * ADDR_W'(gnt_y) + ADDR_W'(gnt_x);

    assign push_tag = '{valid: any_grant, id: gnt_id, oob: gnt_oob};
    // Kill in-flight reads on leaving SERVE so no stale cell reaches a requester
    assign flush    = !serve || start_game;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            seed_q  <= '0;
            deny_q  <= '0;
            addr_q  <= '0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            deny_q  <= deny_d;
            data_q  <= maze_data;
            if (any_grant && !gnt_oob) begin
                addr_q <= gnt_addr;
            end
        end
    end

    maze_tag_pipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_tag_pipe (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .push (push_tag),
        .tail (tail_tag)
    );

    // data_q holds the cell read for the address issued READ_LAT+1 cycles earlier
    assign resp_data    = tail_tag.oob ? WALL : data_q;
    assign disp_valid   = tail_tag.valid && (tail_tag.id == REQ_DISP);
    assign plyr_valid   = tail_tag.valid && (tail_tag.id == REQ_PLYR);
    assign disp_data    = disp_valid && resp_data;
    assign plyr_data    = plyr_valid && resp_data;

    assign seed_out     = seed_q;
    assign gen_start    = (state_q == StGenPulse);
    assign maze_ready   = serve;
    assign maze_address = addr_q;

endmodule

// File: doc/maze_read_arbiter.md
# maze_read_arbiter

Sequences maze generation and shares the single maze read port between the VGA display renderer and the player-movement collision checker. After reset it waits for `start_game` and issues a one-cycle `gen_start` pulse with a latched seed. It waits for `gen_end` to complete a low-then-high handshake, then arbitrates read requests. Each granted (x, y) request becomes a cell address, and the returned cell bit is routed back to the granted requester.

## Interface
- `WIDTH`, 30, maze columns
- `HEIGHT`, 40, maze rows
- `ADDR_W`, 11, maze RAM address width
- `READ_LAT`, 2, cycles from `maze_address` change to valid `maze_data` in the maze generator (its address register plus the RAM)
- `STARVE_LIMIT`, 4, consecutive player denials before the player is forced to win
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start_game`  in  1  level; a (re)generation request, sampled in IDLE and SERVE
- `seed_in`  in  11  seed, captured when `start_game` is accepted
- `seed_out`  out  11  latched seed to the generator
- `gen_start`  out  1  one-cycle generation pulse
- `gen_end`  in  1  generator finished
- `maze_ready`  out  1  high only in SERVE
- `maze_address`  out  ADDR_W  registered read address to the generator
- `maze_data`  in  1  cell bit (0 = FLOOR, 1 = WALL)
- `disp_req`, `plyr_req`  in  1  read requests
- `disp_x`, `plyr_x`  in  6  column
- `disp_y`, `plyr_y`  in  6  row
- `disp_grant`, `plyr_grant`  out  1  combinational acceptance, same cycle as the request
- `disp_valid`, `plyr_valid`  out  1  one-cycle response strobes
- `disp_data`, `plyr_data`  out  1  cell bit, meaningful only while the matching valid is high

## Operation
- States are IDLE, GEN_PULSE, GEN_CLEAR, GEN_WAIT and SERVE.
- IDLE:
  - `start_game`=1 captures `seed_in` into `seed_out` and moves to GEN_PULSE.
- GEN_PULSE:
  - `gen_start`=1 for exactly one cycle, then GEN_CLEAR.
- GEN_CLEAR:
  - Wait for `gen_end`=0, then GEN_WAIT.
  - This state is mandatory because the generator's `gen_end` can stay high from the previous maze for several cycles after `gen_start`.
- GEN_WAIT:
  - Wait for `gen_end`=1, then SERVE.
- SERVE:
  - `maze_ready`=1.
  - `start_game`=1 captures the seed, goes to GEN_PULSE and drops `maze_ready` on the next cycle.
  - Grants are suppressed in any cycle where `start_game`=1.
- Arbitration, SERVE only:
  - At most one grant per cycle.
  - The display wins by default.
  - A player-denial counter increments on each cycle where `plyr_req`=1 and the grant went to the display.
  - The counter clears on a player grant or when `plyr_req`=0.
  - When the counter equals `STARVE_LIMIT`, the player wins that cycle.
- Requesters hold their req and coordinates until granted. A grant completes the handshake; no request is queued.
- Address:
  - `maze_address` <= `WIDTH*y + x`, computed in ADDR_W bits; the maximum is 1199.
  - It is registered at the end of the grant cycle and holds its value between grants.
- Out-of-range requests (x ≥ WIDTH or y ≥ HEIGHT):
  - They are still granted.
  - `maze_address` is left unchanged.
  - The response data is forced to WALL, with the normal latency.
- Tag pipeline:
  - Each grant pushes {valid, requester id, oob flag} into a READ_LAT+2-deep shift register.
  - At the output, the tag's id selects which valid to raise.
  - Data is `maze_data`, or 1 if the oob flag is set.
- Leaving SERVE clears all in-flight tags, so no response is delivered for a pre-regeneration grant.
- Requests made outside SERVE receive no grant.

## Timing
- Reset values:
  - state IDLE
  - `gen_start` 0, `maze_ready` 0
  - `seed_out` 0, `maze_address` 0
  - all grant, valid and data outputs 0
  - denial counter 0
  - tag pipeline empty
- `start_game` sampled at edge E0:
  - `gen_start` is high in cycle E0+1.
  - SERVE is reached at the earliest 2 cycles after `gen_end` is seen low and then high.
- Grant in cycle N:
  - `maze_address` is valid from N+1.
  - The matching valid and data are high in cycle N+READ_LAT+2 (N+4 at the default).
- Back-to-back grants:
  - Responses emerge one per cycle, in grant order.
  - Full throughput is one request per cycle.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronous).
  - The block is in IDLE on release.
- `start_game` while in GEN_PULSE, GEN_CLEAR or GEN_WAIT is ignored.

## Structure
- Shared package `maze_pkg`:
  - FLOOR/WALL constants
  - arbiter state encoding
  - requester-id constants (DISP=0, PLYR=1)
  - default WIDTH, HEIGHT and ADDR_W
- Sub-module `maze_tag_pipe`:
  - parameterised depth
  - synchronous flush input
  - carries {valid, id, oob}
  - async active-low reset

## Test plan
- Reset release, then `start_game` with `seed_in`=11'h2A5:
  - `seed_out`=11'h2A5 and `gen_start` high for exactly 1 cycle.
  - With `gen_end` held high for 3 more cycles, then low, then high: `maze_ready` rises only after the low-to-high sequence.
- Display request (3, 2) alone:
  - `disp_grant` in the same cycle.
  - `maze_address`=63 on the next cycle.
  - `disp_valid` 4 cycles after the grant, with `disp_data`=`maze_data`.
- Both requesters held continuously: the grant pattern is 4 display grants then 1 player grant, repeating.
- Player request (30, 5), out of range:
  - Granted.
  - `maze_address` unchanged.
  - `plyr_valid` with `plyr_data`=1 after 4 cycles.
- `start_game` issued in SERVE with 3 grants in flight:
  - No valid is emitted for those grants.
  - `maze_ready` falls.
  - `gen_start` pulses.
- `reset` asserted low mid-GEN_WAIT and mid-SERVE: all outputs read 0 in the same cycle, and the block is in IDLE.
